windup_gate_mc: RTL and testbench
=================================

Name: windup_gate_mc

Overview:
- Multi-channel, fully synchronous successor to the single-channel wind-up clock gate.
- Each of CH channels holds a BIT-wide down-counter, loaded ("wound") over a shared write port.
- Each channel emits exactly that many single-cycle clock-enable pulses, then stops.
- Drives clock-enable inputs of downstream blocks; no gated clock is produced. Adds saturating accumulate, per-channel pause, clear, done pulses and readback.

Parameters:
- BIT, 16, counter width per channel (>=2).
- CH, 4, number of channels (>=1).
- CH_W, localparam = max(1, $clog2(CH)), channel-select width.

Ports:
- clk_in  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe, one command per cycle.
- wr_ch  input  CH_W  target channel; values >= CH make the write a no-op.
- wr_mode  input  2  command: 00 LOAD, 01 ADD, 10 CLEAR, 11 reserved (no-op).
- wind  input  BIT  operand for LOAD/ADD.
- wr_reload  input  1  reload flag captured with LOAD (see Optional Feature).
- pause  input  CH  per-channel hold; counter frozen, enable suppressed.
- en_out  output  CH  per-channel clock-enable, combinational from state.
- busy  output  CH  counter != 0.
- done  output  CH  registered one-cycle pulse after the final enable cycle.
- remain  output  CH*BIT  flat counter readback; channel i at [i*BIT +: BIT].

Behaviour:
- Reset (rst low, asynchronous): all counters 0, reload registers 0, done 0. Consequently en_out 0 and busy 0. No enables while rst is low; release takes effect at the next posedge.
- hit_i = wr_en & (wr_ch == i) & (wr_mode != 11).
- en_out[i] = (cnt_i != 0) & ~pause[i] & ~hit_i.
- When en_out[i]=1 at a posedge, cnt_i decrements by 1. LOAD of N therefore yields exactly N en_out cycles (when not paused or written).
- Write priority over decrement: in a cycle with hit_i, no decrement occurs and en_out[i]=0.
  - LOAD: cnt_i <= wind.
  - ADD: cnt_i <= min(cnt_i + wind, 2^BIT-1), computed in BIT+1 bits and saturated.
  - CLEAR: cnt_i <= 0, no done pulse.
- done[i] is 1 in the cycle after a decrement takes cnt_i from 1 to 0. It is 0 otherwise, including after CLEAR, LOAD of 0, or reset.
- pause: counter holds value; busy unaffected; writes still accepted while paused.
- Channels are independent: writes to channel j never disturb channel i's count or enable.
- Write of 0 via LOAD to an idle channel: stays idle, no done.
- ADD to an idle channel behaves as LOAD of wind.
- Reset mid-count: counter lost immediately; done not asserted.
- Counters never wrap: decrement stops at 0, ADD saturates.

Optional Feature:
- Macro WINDUP_RELOAD_EN.
- Defined:
  - LOAD captures wind into reload_i and wr_reload into rl_i. CLEAR zeroes rl_i.
  - On the 1->0 decrement with rl_i=1 and reload_i != 0, cnt_i <= reload_i instead of 0.
  - done[i] still pulses the next cycle; busy stays 1.
  - Result is periodic bursts of reload_i enables with no gap cycle.
- Not defined: wr_reload is ignored, no reload registers exist, and every channel is one-shot.

Decomposition:
- Package windup_pkg:
  - mode encodings WM_LOAD=2'b00, WM_ADD=2'b01, WM_CLEAR=2'b10, WM_RSVD=2'b11;
  - saturation helper function sat_add(a, b, width).
- Sub-module windup_channel (BIT parameter), instantiated CH times via generate:
  - inputs: hit, mode, wind, wr_reload, pause;
  - outputs: en, busy, done, cnt.
  - Top does address decode and flattening only.

Test Plan:
- Reset then LOAD ch0 wind=3, pause=0 -> en_out[0] high exactly 3 consecutive cycles; remain ch0 3->2->1->0; done[0] one cycle after the last enable; busy[0] falls with count.
- LOAD ch1=5, assert pause[1] after 2 enables for 4 cycles -> remain ch1 holds 3; en_out[1] 0 while paused; 3 more enables after release (5 total).
- LOAD ch2=16'hFFF0 then ADD wind=16'h0100 -> remain saturates at 16'hFFFF; no enable in the write cycles.
- ch3 counting from 10, CLEAR at remain=4 -> remain 0 next cycle, done[3] never asserted; simultaneous LOAD to ch0 leaves ch3 unaffected until the CLEAR.
- Assert rst low asynchronously mid-count (ch0=7) -> en_out, busy, remain clear without a clock edge; no done after release.
- With WINDUP_RELOAD_EN: LOAD ch0=2, wr_reload=1 -> en_out[0] continuous; done[0] every 2nd cycle; CLEAR stops it. Without the macro, the same stimulus gives 2 enables and one done.

Source files
------------

// File: rtl/windup_gate_mc_pkg.sv
// Shared definitions for the multi-channel wind-up clock-enable gate:
// write-command encodings and the saturating add used by ADD.
package windup_pkg;

  typedef enum logic [1:0] {
    WM_LOAD  = 2'b00,
    WM_ADD   = 2'b01,
    WM_CLEAR = 2'b10,
    WM_RSVD  = 2'b11
  } wr_mode_e;

  // Sum is formed one bit wider than the operands, then clamped to 2^width-1.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/windup_gate_mc_if.sv
// Write port, pause controls and per-channel status of windup_gate_mc.
interface windup_gate_mc_if #(
  parameter int BIT = 16,
  parameter int CH  = 4
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [1:0]      wr_mode;
  logic [BIT-1:0]  wind;
  logic            wr_reload;
  logic [CH-1:0]   pause;
  logic [CH-1:0]   en_out;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   done;
  logic [CH*BIT-1:0] remain;

  modport master (
    output wr_en, wr_ch, wr_mode, wind, wr_reload, pause,
    input  en_out, busy, done, remain
  );

  modport slave (
    input  wr_en, wr_ch, wr_mode, wind, wr_reload, pause,
    output en_out, busy, done, remain
  );
endinterface

// File: rtl/windup_gate_mc_channel.sv
// One wind-up channel: down-counter emitting one enable per count.
// With WINDUP_RELOAD_EN defined, LOAD can arm an automatic reload on expiry.
module windup_channel
  import windup_pkg::*;
#(
  parameter int BIT = 16
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           hit,
  input  logic [1:0]     mode,
  input  logic [BIT-1:0] wind,
  input  logic           wr_reload,
  input  logic           pause,
  output logic           en,
  output logic           busy,
  output logic           done,
  output logic [BIT-1:0] cnt
);

  logic [BIT-1:0] cnt_reg, cnt_next;
  logic           done_reg, done_next;
  logic [BIT-1:0] add_sat;
  logic [BIT-1:0] expire_val;

  assign add_sat = BIT'(sat_add(64'(cnt_reg), 64'(wind), BIT));

`ifdef WINDUP_RELOAD_EN
  logic [BIT-1:0] reload_reg, reload_next;
  logic           rl_reg, rl_next;

  assign expire_val = (rl_reg && (reload_reg != '0)) ? reload_reg : '0;

  always_comb begin
    reload_next = reload_reg;
    rl_next     = rl_reg;
    if (hit && (mode == WM_LOAD)) begin
      reload_next = wind;
      rl_next     = wr_reload;
    end else if (hit && (mode == WM_CLEAR)) begin
      rl_next     = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      reload_reg <= '0;
      rl_reg     <= 1'b0;
    end else begin
      reload_reg <= reload_next;
      rl_reg     <= rl_next;
    end
  end
`else
  logic unused_reload;
  assign unused_reload = wr_reload;
  assign expire_val    = '0;
`endif

  // A write in the same cycle always wins over the decrement.
  assign en   = (cnt_reg != '0) && !pause && !hit;
  assign busy = (cnt_reg != '0);
  assign done = done_reg;
  assign cnt  = cnt_reg;

  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (hit) begin
      case (mode)
        WM_LOAD:  cnt_next = wind;
        WM_ADD:   cnt_next = add_sat;
        WM_CLEAR: cnt_next = '0;
        default:  cnt_next = cnt_reg;
      endcase
    end else if (en) begin
      if (cnt_reg == BIT'(1)) begin
        cnt_next  = expire_val;
        done_next = 1'b1;
      end else begin
        cnt_next  = cnt_reg - BIT'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

endmodule

// File: rtl/windup_gate_mc.sv
// Multi-channel wind-up clock-enable gate: channel decode and readback flattening.
// Optional auto-reload per channel is enabled by defining WINDUP_RELOAD_EN.
module windup_gate_mc
  import windup_pkg::*;
#(
  parameter int BIT = 16,
  parameter int CH  = 4
) (
  input  logic           clk_in,
  input  logic           rst,
  windup_gate_mc_if.slave bus
);

  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] hit;

  // Out-of-range channel numbers and the reserved mode match no channel.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign hit[gi] = bus.wr_en && (bus.wr_ch == CH_W'(gi)) &&
                       (bus.wr_mode != WM_RSVD);

      windup_channel #(.BIT(BIT)) u_ch (
        .clk_in    (clk_in),
        .rst       (rst),
        .hit       (hit[gi]),
        .mode      (bus.wr_mode),
        .wind      (bus.wind),
        .wr_reload (bus.wr_reload),
        .pause     (bus.pause[gi]),
        .en        (bus.en_out[gi]),
        .busy      (bus.busy[gi]),
        .done      (bus.done[gi]),
        .cnt       (bus.remain[gi*BIT +: BIT])
      );
    end
  endgenerate

endmodule

// File: tb/tb_windup_gate_mc.sv
// Directed plus randomized bench for windup_gate_mc against a count-level model.
// Honours WINDUP_RELOAD_EN the same way the design does.
module tb_windup_gate_mc;

  localparam int BIT = 16;
  localparam int CH  = 4;
  localparam longint unsigned MAXV = (64'd1 << BIT) - 64'd1;

  logic clk;
  logic rst;

  windup_gate_mc_if #(.BIT(BIT), .CH(CH)) bus ();

  windup_gate_mc #(.BIT(BIT), .CH(CH)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  longint unsigned cnt_m    [CH];
  longint unsigned reload_m [CH];
  bit              rl_m     [CH];
  bit              done_m   [CH];
  int              en_tally [CH];
  int              done_tally [CH];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      cnt_m[i] = 0; reload_m[i] = 0; rl_m[i] = 0; done_m[i] = 0;
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < CH; i++) begin
      en_tally[i] = 0; done_tally[i] = 0;
    end
  endtask

  function automatic bit hit_of(int i);
    return bus.wr_en && (int'(bus.wr_ch) == i) && (bus.wr_mode != 2'b11);
  endfunction

  task automatic check_all();
    for (int i = 0; i < CH; i++) begin
      logic en_e;
      en_e = rst && (cnt_m[i] != 0) && !bus.pause[i] && !hit_of(i);
      chk($sformatf("en_out[%0d]", i), 64'(bus.en_out[i]), 64'(en_e));
      chk($sformatf("busy[%0d]", i), 64'(bus.busy[i]), 64'(cnt_m[i] != 0));
      chk($sformatf("done[%0d]", i), 64'(bus.done[i]), 64'(done_m[i]));
      chk($sformatf("remain[%0d]", i), 64'(bus.remain[i*BIT +: BIT]), cnt_m[i]);
      if (bus.en_out[i] === 1'b1) en_tally[i]++;
      if (bus.done[i] === 1'b1) done_tally[i]++;
    end
  endtask

  // Apply the specification's per-cycle rules to the counts at a posedge.
  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      bit hit, en;
      longint unsigned sum;
      hit = hit_of(i);
      en  = (cnt_m[i] != 0) && !bus.pause[i] && !hit;
      done_m[i] = 0;
      if (hit) begin
        case (bus.wr_mode)
          2'b00: begin
            cnt_m[i] = bus.wind;
`ifdef WINDUP_RELOAD_EN
            reload_m[i] = bus.wind;
            rl_m[i]     = bus.wr_reload;
`endif
          end
          2'b01: begin
            sum = cnt_m[i] + longint'(bus.wind);
            cnt_m[i] = (sum > MAXV) ? MAXV : sum;
          end
          default: begin
            cnt_m[i] = 0;
            rl_m[i]  = 0;
          end
        endcase
      end else if (en) begin
        if (cnt_m[i] == 1) begin
          done_m[i] = 1;
          cnt_m[i]  = (rl_m[i] && reload_m[i] != 0) ? reload_m[i] : 0;
        end else begin
          cnt_m[i] = cnt_m[i] - 1;
        end
      end
    end
  endtask

  // Inputs are already driven (posedge+1); check at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write(int ch, logic [1:0] mode, logic [BIT-1:0] w, logic rl);
    bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_mode = mode;
    bus.wind = w; bus.wr_reload = rl;
    cycle();
    bus.wr_en = 1'b0; bus.wr_reload = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_mode = 2'b00;
    bus.wind = '0; bus.wr_reload = 1'b0; bus.pause = '0;
    model_reset();
    clear_tally();
    #2;
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // LOAD 3 on ch0: three enables then one done
    clear_tally();
    write(0, 2'b00, 16'd3, 1'b0);
    idle(5);
    chk("ch0_load3_enables", 64'(en_tally[0]), 64'd3);
    chk("ch0_load3_dones", 64'(done_tally[0]), 64'd1);

    // LOAD 5 on ch1, pause after two enables for four cycles
    clear_tally();
    write(1, 2'b00, 16'd5, 1'b0);
    idle(2);
    bus.pause[1] = 1'b1;
    idle(4);
    chk("ch1_paused_hold", 64'(bus.remain[1*BIT +: BIT]), 64'd3);
    bus.pause[1] = 1'b0;
    idle(5);
    chk("ch1_total_enables", 64'(en_tally[1]), 64'd5);

    // Saturating ADD on ch2
    write(2, 2'b00, 16'hFFF0, 1'b0);
    write(2, 2'b01, 16'h0100, 1'b0);
    @(negedge clk);
    chk("ch2_saturated", 64'(bus.remain[2*BIT +: BIT]), 64'hFFFF);
    @(posedge clk); model_step(); #1;
    write(2, 2'b10, 16'h0, 1'b0);

    // ch3 from 10, interleaved LOAD on ch0, CLEAR ch3 at remain 4
    clear_tally();
    write(3, 2'b00, 16'd10, 1'b0);
    idle(1);
    write(0, 2'b00, 16'd2, 1'b0);
    guard = 0;
    while (cnt_m[3] != 4 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("ch3_reach4_in_budget", 64'(guard < 20), 64'd1);
    write(3, 2'b10, 16'h0, 1'b0);
    idle(4);
    chk("ch3_no_done_after_clear", 64'(done_tally[3]), 64'd0);

    // Reload behaviour (or one-shot without the macro)
    clear_tally();
    write(0, 2'b00, 16'd2, 1'b1);
    idle(8);
`ifdef WINDUP_RELOAD_EN
    chk("ch0_reload_enables", 64'(en_tally[0]), 64'd8);
    chk("ch0_reload_dones", 64'(done_tally[0]), 64'd3);
`else
    chk("ch0_oneshot_enables", 64'(en_tally[0]), 64'd2);
    chk("ch0_oneshot_dones", 64'(done_tally[0]), 64'd1);
`endif
    write(0, 2'b10, 16'h0, 1'b0);
    idle(3);

    // Asynchronous reset mid-count
    clear_tally();
    write(0, 2'b00, 16'd7, 1'b0);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_en_out", 64'(bus.en_out), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_remain", 64'(bus.remain), 64'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);
    chk("no_done_after_rst", 64'(done_tally[0]), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.wr_en     = ($urandom_range(0, 2) == 0);
      bus.wr_ch     = 2'($urandom_range(0, CH - 1));
      bus.wr_mode   = 2'($urandom_range(0, 3));
      bus.wind      = ($urandom_range(0, 7) == 0) ? BIT'($urandom) : BIT'($urandom_range(0, 6));
      bus.wr_reload = 1'($urandom_range(0, 1));
      for (int i = 0; i < CH; i++) bus.pause[i] = ($urandom_range(0, 7) == 0);
      cycle();
    end
    bus.wr_en = 1'b0; bus.pause = '0;
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
